// File: rtl/pipe_mem_stage.sv
// Memory-access stage: posts stores into an in-order store buffer that drains
// one entry per cycle through RAM port B, and serves loads from RAM port A with
// youngest-first forwarding out of the buffer. Load results are registered.
module pipe_mem_stage #(
    parameter int WORD_SIZE = 16,
    parameter int MEM_SIZE  = 32,
    parameter int ADDR_SIZE = $clog2(MEM_SIZE),
    parameter int SB_DEPTH  = 4,
    parameter int RD_SIZE   = 3
) (
    input  logic                          i_CLK,
    input  logic                          i_RST,
    input  logic                          i_req_valid,
    output logic                          o_req_ready,
    input  logic                          i_req_we,
    input  logic [ADDR_SIZE-1:0]          i_req_addr,
    input  logic [WORD_SIZE-1:0]          i_req_wdata,
    input  logic [RD_SIZE-1:0]            i_req_rd,
    output logic                          o_read_en_A,
    output logic [ADDR_SIZE-1:0]          o_read_addr_A,
    input  logic [WORD_SIZE-1:0]          i_read_data_A,
    output logic                          o_write_en_B,
    output logic [ADDR_SIZE-1:0]          o_write_addr_B,
    output logic [WORD_SIZE-1:0]          o_write_data_B,
    output logic                          o_wb_valid,
    output logic [RD_SIZE-1:0]            o_wb_rd,
    output logic [WORD_SIZE-1:0]          o_wb_data,
    output logic [$clog2(SB_DEPTH):0]     o_sb_count,
    output logic                          o_sb_empty
);

    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Store buffer state. Entries are reset explicitly, so they live in
    // flops rather than a RAM macro.
    logic [PTR_W-1:0]     head_reg;
    logic [PTR_W-1:0]     tail_reg;
    logic [CNT_W-1:0]     count_reg;
    logic [ADDR_SIZE-1:0] sb_addr_reg [SB_DEPTH];
    logic [WORD_SIZE-1:0] sb_data_reg [SB_DEPTH];

    logic accept;
    logic push;
    logic pop;
    logic load_acc;

    logic                 fwd_hit;
    logic [WORD_SIZE-1:0] fwd_data;
    logic [PTR_W-1:0]     fwd_idx;
    logic [WORD_SIZE-1:0] load_data_next;

    // Readiness depends only on registered occupancy, never on the same-cycle pop.
    assign o_req_ready = (count_reg != CNT_W'(SB_DEPTH));
    assign accept      = i_req_valid && o_req_ready;
    assign push        = accept && i_req_we;
    assign load_acc    = accept && !i_req_we;
    assign pop         = (count_reg != '0);

    // Port A is only exercised by an accepted load.
    assign o_read_en_A   = load_acc;
    assign o_read_addr_A = load_acc ? i_req_addr : '0;

    // Port B presents the head entry whenever anything is buffered.
    assign o_write_en_B   = pop;
    assign o_write_addr_B = pop ? sb_addr_reg[head_reg] : '0;
    assign o_write_data_B = pop ? sb_data_reg[head_reg] : '0;

    assign o_sb_count = count_reg;
    assign o_sb_empty = (count_reg == '0);

    // Per-entry storage: written only when a store lands on this slot.
    generate
        for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_entry
            always_ff @(posedge i_CLK or negedge i_RST) begin
                if (!i_RST) begin
                    sb_addr_reg[gi] <= '0;
                    sb_data_reg[gi] <= '0;
                end else if (push && (tail_reg == PTR_W'(gi))) begin
                    sb_addr_reg[gi] <= i_req_addr;
                    sb_data_reg[gi] <= i_req_wdata;
                end
            end
        end
    endgenerate

    // Pointer and occupancy bookkeeping; push and pop in one cycle cancel.
    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push) begin
                tail_reg <= tail_reg + 1'b1;
            end
            if (pop) begin
                head_reg <= head_reg + 1'b1;
            end
            if (push && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop && !push) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    // Forwarding search from oldest to youngest so the last match wins.
    // The head counts as live even on the cycle it is being written to RAM.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int k = 0; k < SB_DEPTH; k++) begin
            fwd_idx = head_reg + PTR_W'(k);
            if ((CNT_W'(k) < count_reg) && (sb_addr_reg[fwd_idx] == i_req_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = sb_data_reg[fwd_idx];
            end
        end
    end

    assign load_data_next = fwd_hit ? fwd_data : i_read_data_A;

    // Writeback register: one-cycle valid pulse per load, data/rd held otherwise.
    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            o_wb_valid <= 1'b0;
            o_wb_rd    <= '0;
            o_wb_data  <= '0;
        end else begin
            o_wb_valid <= load_acc;
            if (load_acc) begin
                o_wb_rd   <= i_req_rd;
                o_wb_data <= load_data_next;
            end
        end
    end

endmodule
